// File: rtl/ex_wb_stage.sv
// EX->WB pipeline register: holds the ALU result for writeback, owns the committed
// flag register, and resolves branches into a one-cycle redirect pulse.
module ex_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              carry_in,
  input  logic              zero_in,
  input  logic              sign_in,
  input  logic              ovf_in,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wen,
  input  logic              in_flag_we,
  input  logic              in_br_en,
  input  logic [3:0]        in_br_cond,
  input  logic [DATA_W-1:0] in_br_target,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_wen,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic [3:0]        flags_q,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic accept;
  logic cond_hit;
  logic br_fire;
  logic stalled;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign stalled  = out_valid && !out_ready && !flush;

  // Condition tested against flags_q before this edge's update, so a
  // flag-writing branch sees the previous instruction's flags.
  always_comb begin
    cond_hit = 1'b0;
    case (in_br_cond)
      4'b0000: cond_hit = 1'b1;
      4'b0001: cond_hit = flags_q[2];
      4'b0010: cond_hit = !flags_q[2];
      4'b0011: cond_hit = flags_q[3];
      4'b0100: cond_hit = !flags_q[3];
      4'b0101: cond_hit = flags_q[1];
      4'b0110: cond_hit = !flags_q[1];
      4'b0111: cond_hit = flags_q[0];
      4'b1000: cond_hit = !flags_q[0];
      default: cond_hit = 1'b0;
    endcase
  end

  assign br_fire = accept && in_br_en && cond_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      wb_data   <= '0;
      wb_rd     <= '0;
      wb_wen    <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
      flags_q   <= '0;
      stall_cnt <= '0;
    end else begin
      br_taken <= br_fire;
      if (br_fire) br_target <= in_br_target;

      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        wb_data   <= alu_out;
        wb_rd     <= in_rd;
        wb_wen    <= in_wen;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept && in_flag_we) flags_q <= {carry_in, zero_in, sign_in, ovf_in};

      if (stalled && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage; a second instance with a 4-bit counter covers saturation.
module tb_ex_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] alu_out = '0;
  logic        carry_in = 1'b0, zero_in = 1'b0, sign_in = 1'b0, ovf_in = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_wen = 1'b0, in_flag_we = 1'b0, in_br_en = 1'b0;
  logic [3:0]  in_br_cond = '0;
  logic [31:0] in_br_target = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, wb_wen, br_taken;
  logic [31:0] wb_data, br_target;
  logic [4:0]  wb_rd;
  logic [3:0]  flags_q;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid, s_wb_wen, s_br_taken;
  logic [31:0] s_wb_data, s_br_target;
  logic [4:0]  s_wb_rd;
  logic [3:0]  s_flags_q;
  logic [3:0]  s_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_out(alu_out),
    .carry_in(carry_in), .zero_in(zero_in), .sign_in(sign_in), .ovf_in(ovf_in),
    .in_rd(in_rd), .in_wen(in_wen), .in_flag_we(in_flag_we), .in_br_en(in_br_en),
    .in_br_cond(in_br_cond), .in_br_target(in_br_target), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_wen(wb_wen), .br_taken(br_taken), .br_target(br_target), .flags_q(flags_q),
    .stall_cnt(stall_cnt)
  );

  ex_wb_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .alu_out(alu_out),
    .carry_in(carry_in), .zero_in(zero_in), .sign_in(sign_in), .ovf_in(ovf_in),
    .in_rd(in_rd), .in_wen(in_wen), .in_flag_we(in_flag_we), .in_br_en(in_br_en),
    .in_br_cond(in_br_cond), .in_br_target(in_br_target), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .wb_data(s_wb_data), .wb_rd(s_wb_rd),
    .wb_wen(s_wb_wen), .br_taken(s_br_taken), .br_target(s_br_target), .flags_q(s_flags_q),
    .stall_cnt(s_stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; alu_out = '0; in_rd = '0; in_wen = 1'b0; in_flag_we = 1'b0;
    carry_in = 1'b0; zero_in = 1'b0; sign_in = 1'b0; ovf_in = 1'b0;
    in_br_en = 1'b0; in_br_cond = '0; in_br_target = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0h want 0", out_valid); end
    n_cmp++; if (flags_q !== 4'h0) begin n_err++; $display("FAIL rst_flags got %0h want 0", flags_q); end
    n_cmp++; if (stall_cnt !== 16'h0) begin n_err++; $display("FAIL rst_stall got %0h want 0", stall_cnt); end
    n_cmp++; if (wb_data !== 32'h0 || wb_wen !== 1'b0 || br_taken !== 1'b0) begin
      n_err++; $display("FAIL rst_wb got data=%0h wen=%0h br=%0h want 0/0/0", wb_data, wb_wen, br_taken); end
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %0h want 1", in_ready); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    in_valid = 1'b1; alu_out = 32'h5; in_rd = 5'd3; in_wen = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || wb_data !== 32'h5 || wb_rd !== 5'd3 || wb_wen !== 1'b1) begin
      n_err++; $display("FAIL stream_first got v=%0h d=%0h rd=%0d want 1/5/3", out_valid, wb_data, wb_rd); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready1 got %0h want 1", in_ready); end
    alu_out = 32'hFFFF_FFFF; in_rd = 5'd4;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || wb_data !== 32'hFFFF_FFFF || wb_rd !== 5'd4) begin
      n_err++; $display("FAIL stream_second got v=%0h d=%0h rd=%0d want 1/ffffffff/4", out_valid, wb_data, wb_rd); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready2 got %0h want 1", in_ready); end
    idle();
    tick();
    n_cmp++; if (out_valid !== 1'b0 || wb_data !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL stream_drain got v=%0h d=%0h want 0/ffffffff", out_valid, wb_data); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL stream_stall got %0d want 0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; alu_out = 32'hA5; in_rd = 5'd7; in_wen = 1'b1;
    tick();
    out_ready = 1'b0;
    alu_out = 32'hBB; in_rd = 5'd9;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %0h want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (wb_data !== 32'hA5 || wb_rd !== 5'd7 || out_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold%0d got d=%0h rd=%0d v=%0h want a5/7/1", i, wb_data, wb_rd, out_valid); end
    end
    n_cmp++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL bp_stall got %0d want 3", stall_cnt); end
    idle();
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_drain got v=%0h rdy=%0h want 0/1", out_valid, in_ready); end
    n_cmp++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL bp_stall_hold got %0d want 3", stall_cnt); end
  endtask

  task automatic test_flags_branch();
    in_valid = 1'b1; in_wen = 1'b1; in_flag_we = 1'b1; zero_in = 1'b1; alu_out = 32'h0;
    tick();
    n_cmp++; if (flags_q !== 4'b0100) begin n_err++; $display("FAIL fl_add got %b want 0100", flags_q); end
    idle();
    in_valid = 1'b1; in_br_en = 1'b1; in_br_cond = 4'b0001; in_br_target = 32'h40;
    tick();
    n_cmp++; if (br_taken !== 1'b1 || br_target !== 32'h40) begin
      n_err++; $display("FAIL br_z_taken got t=%0h tgt=%0h want 1/40", br_taken, br_target); end
    n_cmp++; if (out_valid !== 1'b1 || wb_wen !== 1'b0) begin
      n_err++; $display("FAIL br_slot got v=%0h wen=%0h want 1/0", out_valid, wb_wen); end
    in_br_cond = 4'b0010; in_br_target = 32'h80;
    tick();
    n_cmp++; if (br_taken !== 1'b0) begin n_err++; $display("FAIL br_nz got %0h want 0", br_taken); end
    in_br_cond = 4'b0000; in_br_target = 32'h123;
    tick();
    n_cmp++; if (br_taken !== 1'b1 || br_target !== 32'h123) begin
      n_err++; $display("FAIL br_always got t=%0h tgt=%0h want 1/123", br_taken, br_target); end
    in_br_cond = 4'b1001;
    tick();
    n_cmp++; if (br_taken !== 1'b0) begin n_err++; $display("FAIL br_code9 got %0h want 0", br_taken); end
    in_br_cond = 4'b0100; in_br_target = 32'h200;
    tick();
    n_cmp++; if (br_taken !== 1'b1 || br_target !== 32'h200) begin
      n_err++; $display("FAIL br_nc got t=%0h tgt=%0h want 1/200", br_taken, br_target); end
    idle();
    tick();
    n_cmp++; if (br_taken !== 1'b0) begin n_err++; $display("FAIL br_pulse got %0h want 0", br_taken); end
  endtask

  task automatic test_hazard();
    in_valid = 1'b1; in_flag_we = 1'b1;
    tick();
    n_cmp++; if (flags_q !== 4'b0000) begin n_err++; $display("FAIL hz_clear got %b want 0000", flags_q); end
    in_br_en = 1'b1; in_br_cond = 4'b0001; in_br_target = 32'h300; zero_in = 1'b1;
    tick();
    n_cmp++; if (br_taken !== 1'b0) begin n_err++; $display("FAIL hz_taken got %0h want 0", br_taken); end
    n_cmp++; if (flags_q !== 4'b0100) begin n_err++; $display("FAIL hz_flags got %b want 0100", flags_q); end
    idle();
    tick();
  endtask

  task automatic test_flush();
    in_valid = 1'b1; alu_out = 32'h77; in_rd = 5'd2; in_wen = 1'b1;
    tick();
    alu_out = 32'h99; in_flag_we = 1'b1; carry_in = 1'b1; zero_in = 1'b0;
    in_br_en = 1'b1; in_br_cond = 4'b0000; in_br_target = 32'h500; flush = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid got %0h want 0", out_valid); end
    n_cmp++; if (flags_q !== 4'b0100) begin n_err++; $display("FAIL fl_flags got %b want 0100", flags_q); end
    n_cmp++; if (br_taken !== 1'b0 || wb_data !== 32'h77) begin
      n_err++; $display("FAIL fl_br got t=%0h d=%0h want 0/77", br_taken, wb_data); end
    n_cmp++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL fl_stall got %0d want 3", stall_cnt); end
    idle();
  endtask

  task automatic test_saturation();
    in_valid = 1'b1; alu_out = 32'h1234; in_rd = 5'd5;
    tick();
    idle();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    n_cmp++; if (s_stall_cnt !== 4'hF) begin n_err++; $display("FAIL sat_small got %0d want 15", s_stall_cnt); end
    n_cmp++; if (stall_cnt !== 16'd23) begin n_err++; $display("FAIL sat_wide got %0d want 23", stall_cnt); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (s_stall_cnt !== 4'hF || out_valid !== 1'b0) begin
      n_err++; $display("FAIL sat_hold got %0d v=%0h want 15/0", s_stall_cnt, out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; alu_out = 32'hCAFE; in_flag_we = 1'b1; carry_in = 1'b1;
    in_br_en = 1'b1; in_br_cond = 4'b0000; in_br_target = 32'h55;
    tick();
    idle();
    n_cmp++; if (out_valid !== 1'b1 || br_taken !== 1'b1 || flags_q !== 4'b1000) begin
      n_err++; $display("FAIL ar_pre got v=%0h t=%0h f=%b want 1/1/1000", out_valid, br_taken, flags_q); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || br_taken !== 1'b0) begin
      n_err++; $display("FAIL ar_vld got v=%0h t=%0h want 0/0", out_valid, br_taken); end
    n_cmp++; if (flags_q !== 4'h0 || stall_cnt !== 16'h0 || wb_data !== 32'h0 || br_target !== 32'h0) begin
      n_err++; $display("FAIL ar_state got f=%b s=%0d d=%0h tgt=%0h want 0", flags_q, stall_cnt, wb_data, br_target); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ar_ready got %0h want 1", in_ready); end
    #1 rst = 1'b1;
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    tick();
    test_streaming();
    test_backpressure();
    test_flags_branch();
    test_hazard();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Pipeline register between the ALU and the register-file writeback port.
- Latches the ALU result and destination, and owns the architectural flag register (C, Z, S, V).
- Resolves conditional branches against the committed flags and emits a one-cycle redirect pulse to fetch.
- Uses a valid/ready handshake on both sides so writeback back-pressure stalls the ALU cleanly.

Parameters:
- DATA_W, 32, width of ALU result and branch target.
- REG_AW, 5, width of destination register index.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU side presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- alu_out  in  DATA_W  ALU result.
- carry_in, zero_in, sign_in, ovf_in  in  1 each  ALU flags.
- in_rd  in  REG_AW  destination register.
- in_wen  in  1  instruction writes the register file.
- in_flag_we  in  1  instruction updates flags (add/addi only; logic, shift and comp instructions drive 0).
- in_br_en  in  1  instruction is a branch.
- in_br_cond  in  4  branch condition code.
- in_br_target  in  DATA_W  branch target address.
- flush  in  1  synchronous kill of the held entry and of any same-cycle accept.
- out_valid  out  1  writeback entry valid.
- out_ready  in  1  writeback consumes the entry.
- wb_data  out  DATA_W  held result.
- wb_rd  out  REG_AW  held destination.
- wb_wen  out  1  held write enable.
- br_taken  out  1  one-cycle redirect pulse.
- br_target  out  DATA_W  redirect address, valid while br_taken=1.
- flags_q  out  4  committed flags {C,Z,S,V}.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid, wb_wen and br_taken clear to 0.
  - wb_data, wb_rd, br_target, flags_q and stall_cnt clear to 0.
  - in_ready is 1 once rst deasserts.
- Acceptance:
  - in_ready = !out_valid || out_ready (combinational; single-entry pipe, no bubble on back-to-back traffic).
  - accept = in_valid && in_ready && !flush.
- On accept (next edge):
  - out_valid=1; wb_data, wb_rd and wb_wen load from the inputs.
  - Latency in->out is 1 cycle.
- Drain: if out_valid && out_ready && !accept, out_valid=0 next edge. Held data is not cleared.
- Hold: if out_valid && !out_ready, all wb_* outputs stay stable and in_ready=0.
- Flags:
  - On accept with in_flag_we=1, flags_q <= {carry_in, zero_in, sign_in, ovf_in}.
  - Otherwise flags_q holds. Flags update at accept, not at writeback.
- Branch resolution (at accept with in_br_en=1):
  - Evaluated against flags_q as it stood before this edge. If in_flag_we is also set, the branch still uses the old flags.
  - Codes: 0000 always; 0001 Z=1; 0010 Z=0; 0011 C=1; 0100 C=0; 0101 S=1; 0110 S=0; 0111 V=1; 1000 V=0.
  - Codes 1001-1111 are never taken.
  - If taken: br_taken=1 and br_target=in_br_target for exactly the next cycle, independent of out_ready. Otherwise br_taken=0.
  - A branch entry still occupies the output slot; its wb_wen follows in_wen.
- Flush:
  - On an edge with flush=1: out_valid <= 0, no accept, no flag update, br_taken <= 0.
  - flush has priority over out_ready and in_valid.
  - flush does not reset stall_cnt.
- stall_cnt: increments each cycle out_valid && !out_ready && !flush. It saturates at all-ones and does not wrap.
- No X propagation: when out_valid=0, wb_wen is treated as don't-care by the consumer, but it must hold a defined value.

Test Plan:
- Reset: rst=0 for mid-transfer entry with out_valid=1 -> out_valid=0, flags_q=0000, stall_cnt=0, br_taken=0 asynchronously, before the next clk edge.
- Streaming: accept alu_out=0x00000005 rd=3, then 0xFFFFFFFF rd=4 with out_ready=1 held -> wb_data=5 then 0xFFFFFFFF on consecutive cycles; in_ready stays 1.
- Back-pressure: out_ready=0 for 3 cycles with one entry held -> in_ready=0, wb_data stable, stall_cnt=3; out_ready=1 -> entry drains, in_ready=1.
- Flags/branch:
  - add with zero_in=1, in_flag_we=1 -> flags_q=0100.
  - Next branch cond 0001 target 0x40 -> br_taken=1 for one cycle, br_target=0x40.
  - Cond 0010 -> br_taken=0.
- Same-cycle hazard: flags_q=0000, accept branch cond 0001 with in_flag_we=1, zero_in=1 -> not taken; flags_q becomes 0100.
- Flush: flush=1 while in_valid=1 and an entry is held -> out_valid=0 next cycle, flags_q unchanged, no br_taken.
- Saturation: force CNT_W=4, stall 20 cycles -> stall_cnt=15.
